// File: rtl/serial_adder_ctrl_if.sv
// Handshake and data bundle for the bit-serial add/subtract sequencer.
// The requester drives the operation. The sequencer returns status and the result.
interface serial_adder_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;

  modport master (
    output start, sub, a, b,
    input  ready, busy, done, sum, cout, overflow
  );

  modport slave (
    input  start, sub, a, b,
    output ready, busy, done, sum, cout, overflow
  );
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract sequencer. One FullAdder cell is reused for WIDTH
// cycles, LSB first. Subtraction is done as a + ~b + 1: the inverted B is
// loaded and the carry is seeded with 1.

// The existing one-bit full adder cell.
module FullAdder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic cout,
  output logic sum
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  serial_adder_ctrl_if.slave   bus
);

  localparam int              CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]   LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;

  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [WIDTH-1:0] r_sr;
  logic             r_c;
  logic [CW-1:0]    r_cnt;
  logic             r_c_msb_in;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_overflow;

  logic             w_fa_sum;
  logic             w_fa_cout;
  logic             w_last;
  logic             w_c_msb;
  logic [WIDTH-1:0] w_sr_next;

  FullAdder u_fa (
    .a    (r_sa[0]),
    .b    (r_sb[0]),
    .cin  (r_c),
    .cout (w_fa_cout),
    .sum  (w_fa_sum)
  );

  assign w_last    = (r_cnt == LAST_BIT);
  assign w_sr_next = {w_fa_sum, r_sr[WIDTH-1:1]};
  // On the last bit the carry flop still holds the carry into the MSB.
  assign w_c_msb   = w_last ? r_c : r_c_msb_in;

  assign bus.sum      = r_sum;
  assign bus.cout     = r_cout;
  assign bus.overflow = r_overflow;

  // Next-state logic and status outputs, which are decoded only from the state.
  always_comb begin
    // NOTE: every output gets a default first. No path can then leave one unassigned and infer a latch.
    w_next    = r_state;
    bus.ready = 1'b0;
    bus.busy  = 1'b0;
    bus.done  = 1'b0;
    case (r_state)
      S_IDLE: begin
        bus.ready = 1'b1;
        if (bus.start) w_next = S_RUN;
      end
      S_RUN: begin
        bus.busy = 1'b1;
        if (w_last) w_next = S_DONE;
      end
      S_DONE: begin
        bus.done = 1'b1;
        w_next   = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments only. All flops then update together at the edge.
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Datapath: load the operands on accept, then shift one bit per cycle in RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the datapath flops are reset as well, so an aborted operation leaves the result at 0.
    if (!rst_n) begin
      r_sa       <= '0;
      r_sb       <= '0;
      r_sr       <= '0;
      r_c        <= 1'b0;
      r_cnt      <= '0;
      r_c_msb_in <= 1'b0;
      r_sum      <= '0;
      r_cout     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_sa  <= bus.a;
            r_sb  <= bus.sub ? ~bus.b : bus.b;
            r_c   <= bus.sub;
            r_cnt <= '0;
          end
        end
        S_RUN: begin
          r_sa  <= r_sa >> 1;
          r_sb  <= r_sb >> 1;
          r_sr  <= w_sr_next;
          r_c   <= w_fa_cout;
          r_cnt <= r_cnt + CW'(1);
          if (w_last) begin
            r_c_msb_in <= r_c;
            r_sum      <= w_sr_next;
            r_cout     <= w_fa_cout;
            r_overflow <= w_c_msb ^ w_fa_cout;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl (WIDTH=8): directed cases plus a
// random sweep, compared with a plain-arithmetic a +/- b reference model.
module tb_serial_adder_ctrl;

  localparam int W = 8;

  logic clk;
  logic rst_n;

  int n_checks = 0;
  int n_errors = 0;
  int n_done   = 0;
  int n_accept = 0;

  // Result the DUT must be holding between completions.
  logic [W-1:0] held_sum;
  logic         held_cout;
  logic         held_ovf;

  serial_adder_ctrl_if #(.WIDTH(W)) bus ();

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count done pulses. Sampling is on the falling edge.
  always @(negedge clk) if (bus.done === 1'b1) n_done++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain signed and unsigned arithmetic on the operand values.
  task automatic model(input logic [W-1:0] op_a, input logic [W-1:0] op_b, input logic op_sub,
                       output logic [W-1:0] e_sum, output logic e_cout, output logic e_ovf);
    int ua, ub, sa, sb, ur, sr;
    ua = int'(op_a);
    ub = int'(op_b);
    sa = int'($signed(op_a));
    sb = int'($signed(op_b));
    ur = op_sub ? (ua - ub) : (ua + ub);
    sr = op_sub ? (sa - sb) : (sa + sb);
    e_sum  = W'(ur);
    e_cout = op_sub ? (ua >= ub) : (ur > (1 << W) - 1);
    e_ovf  = (sr > (1 << (W-1)) - 1) || (sr < -(1 << (W-1)));
  endtask

  task automatic scramble_inputs(input bit pulse_start);
    bus.a     = W'($urandom);
    bus.b     = W'($urandom);
    bus.sub   = 1'($urandom);
    bus.start = pulse_start;
  endtask

  // Run one operation from the falling edge onward. With noise=1, start stays
  // high and the operand inputs keep changing through RUN and DONE.
  task automatic do_op(input logic [W-1:0] op_a, input logic [W-1:0] op_b, input logic op_sub,
                       input bit noise,
                       output logic [W-1:0] got_sum, output logic got_cout, output logic got_ovf);
    logic [W-1:0] e_sum;
    logic         e_cout, e_ovf;
    int           edges;
    bit           held_ok;
    int           done_before;
    model(op_a, op_b, op_sub, e_sum, e_cout, e_ovf);
    edges = 0;
    while (bus.ready !== 1'b1 && edges < 50) begin
      @(negedge clk);
      edges++;
    end
    check("ready_before_start", 32'(bus.ready), 32'd1);
    bus.a = op_a; bus.b = op_b; bus.sub = op_sub; bus.start = 1'b1;
    done_before = n_done;
    @(posedge clk);                       // accept edge E0
    @(negedge clk);
    n_accept++;
    scramble_inputs(noise);
    check("status_after_accept", 32'({bus.ready, bus.busy, bus.done}), 32'b010);
    edges   = 0;
    held_ok = 1'b1;
    while (bus.done !== 1'b1 && edges < 40) begin
      if ({bus.sum, bus.cout, bus.overflow} !== {held_sum, held_cout, held_ovf}) held_ok = 1'b0;
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (noise) scramble_inputs(1'b1);
    end
    check("result_held_until_done", 32'(held_ok), 32'd1);
    check("latency_edges_after_e0", 32'(edges), 32'(W));
    check("sum", 32'(bus.sum), 32'(e_sum));
    check("cout", 32'(bus.cout), 32'(e_cout));
    check("overflow", 32'(bus.overflow), 32'(e_ovf));
    got_sum  = bus.sum;
    got_cout = bus.cout;
    got_ovf  = bus.overflow;
    held_sum = e_sum; held_cout = e_cout; held_ovf = e_ovf;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    check("idle_after_done", 32'({bus.ready, bus.busy, bus.done}), 32'b100);
    check("one_done_per_op", 32'(n_done - done_before), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] s;
    logic         c, v;
    int           d0;

    bus.start = 1'b0; bus.sub = 1'b0; bus.a = '0; bus.b = '0;
    held_sum = '0; held_cout = 1'b0; held_ovf = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_status", 32'({bus.ready, bus.busy, bus.done}), 32'b100);
    check("reset_result", 32'({bus.sum, bus.cout, bus.overflow}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: basic add with signed overflow
    do_op(8'h3C, 8'h5A, 1'b0, 1'b0, s, c, v);
    check("t1_sum", 32'(s), 32'h96);
    check("t1_flags", 32'({c, v}), 32'b01);

    // 2: carry out, then back-to-back at the earliest ready
    do_op(8'hFF, 8'h01, 1'b0, 1'b0, s, c, v);
    check("t2a_sum", 32'(s), 32'h00);
    check("t2a_flags", 32'({c, v}), 32'b10);
    do_op(8'h7F, 8'h00, 1'b0, 1'b0, s, c, v);
    check("t2b_sum", 32'(s), 32'h7F);
    check("t2b_flags", 32'({c, v}), 32'b00);

    // 3: subtraction with borrow, and subtraction with signed overflow
    do_op(8'h05, 8'h07, 1'b1, 1'b0, s, c, v);
    check("t3a_sum", 32'(s), 32'hFE);
    check("t3a_flags", 32'({c, v}), 32'b00);
    do_op(8'h80, 8'h01, 1'b1, 1'b0, s, c, v);
    check("t3b_sum", 32'(s), 32'h7F);
    check("t3b_flags", 32'({c, v}), 32'b11);

    // 4: start and operand noise during RUN and DONE is ignored
    d0 = n_done;
    do_op(8'h10, 8'h20, 1'b0, 1'b1, s, c, v);
    check("t4_sum", 32'(s), 32'h30);
    repeat (4) begin
      @(negedge clk);
      check("t4_no_second_op", 32'({bus.ready, bus.busy}), 32'b10);
    end
    check("t4_single_done", 32'(n_done - d0), 32'd1);

    // 5: reset in the middle of RUN
    d0 = n_done;
    bus.a = 8'hAA; bus.b = 8'h55; bus.sub = 1'b0; bus.start = 1'b1;
    @(posedge clk);                       // E0
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(posedge clk);            // E1..E3
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_status_in_reset", 32'({bus.ready, bus.busy, bus.done}), 32'b100);
    check("t5_sum_in_reset", 32'(bus.sum), 32'h00);
    held_sum = '0; held_cout = 1'b0; held_ovf = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("t5_no_done_after_abort", 32'(n_done - d0), 32'd0);
    check("t5_sum_after_abort", 32'(bus.sum), 32'h00);
    do_op(8'h01, 8'h01, 1'b0, 1'b0, s, c, v);
    check("t5_sum", 32'(s), 32'h02);

    // 6: random sweep, with random gaps between operations
    for (int i = 0; i < 200; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      do_op(W'($urandom), W'($urandom), 1'($urandom), 1'b0, s, c, v);
    end
    repeat (3) @(negedge clk);
    check("done_count_eq_accepts", 32'(n_done), 32'(n_accept));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/serial_adder_ctrl.md
# serial_adder_ctrl

Bit-serial add/subtract sequencer that time-shares one instance of the existing one-bit `FullAdder` cell across WIDTH-bit operands. It processes one bit per clock, LSB first. It sits in the ALU next to the combinational adders as the low-area arithmetic path. It accepts an operation through a start/ready handshake, runs for WIDTH cycles, then presents a registered result with a one-cycle `done` pulse.

## Interface

- `WIDTH`, default 8: operand/result width in bits; legal range 2..32.

- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `start`  in  1  request; accepted only on an edge where `ready`=1.
- `sub`  in  1  0 = a+b, 1 = a−b; sampled with `start`.
- `a`  in  WIDTH  operand A; sampled with `start`.
- `b`  in  WIDTH  operand B; sampled with `start`.
- `ready`  out  1  controller idle; can accept `start`.
- `busy`  out  1  operation in progress.
- `done`  out  1  one-cycle pulse; result outputs just updated.
- `sum`  out  WIDTH  registered result; held until the next completion.
- `cout`  out  1  final carry out; for sub, 1 = no borrow (a ≥ b unsigned).
- `overflow`  out  1  two's-complement overflow of the completed operation.

## Operation

- Exactly one `FullAdder` instance, ports a/b/cin/cout/sum. No other adder logic is permitted.
- Internal regs:
  - operand shift registers `sa` and `sb` (WIDTH each)
  - result shift register `sr` (WIDTH)
  - carry flop `c`
  - bit counter `cnt` ($clog2(WIDTH) bits)
  - flop `c_msb_in`, the carry into the MSB
- FSM states:
  - IDLE: `ready`=1. On `start`=1, load `sa`=a. Load `sb`=b when `sub`=0, or `sb`=~b when `sub`=1. Set `c`=`sub`, `cnt`=0, go to RUN.
  - RUN: `busy`=1. Adder inputs are `sa[0]`, `sb[0]`, `c`. Each cycle:
    - shift `sa` and `sb` right;
    - shift the adder sum into the MSB of `sr` (right shift);
    - `c` ← adder cout;
    - `cnt`++.
    - When `cnt`=WIDTH−1, capture `c_msb_in`=`c` before the update.
    - On the edge where `cnt`=WIDTH−1: `sum` ← final `sr` (including this bit), `cout` ← adder cout, `overflow` ← `c` XOR adder cout. Go to DONE.
  - DONE: `done`=1 for exactly one cycle, `ready`=0, `busy`=0. Next state is IDLE unconditionally.
- Arithmetic is mod 2^WIDTH. Subtraction is a + ~b + 1.
- `start` in RUN or DONE is ignored: it is not queued and has no effect on the in-flight operation.
- `a`, `b` and `sub` may change freely after the accept edge; only the latched copies are used.

## Timing

- Reset (`rst_n`=0, async): state=IDLE, `ready`=1, `busy`=0, `done`=0, `sum`=0, `cout`=0, `overflow`=0. All internal regs are 0.
- Reset is effective immediately, including mid-RUN. The aborted operation produces no `done` and leaves `sum` at 0.
- Accept edge E0 (IDLE, `start`=1): after E0, `busy`=1 and `ready`=0.
- Bit k is processed on edge E(k+1), for k = 0..WIDTH−1.
- Result outputs and `done` become visible after edge E(WIDTH). `done` falls after E(WIDTH+1), when `ready` returns to 1.
- Latency is WIDTH+1 edges from accept to `done` high. Throughput is one op per WIDTH+2 cycles; the earliest next accept is edge E(WIDTH+2).
- `ready`, `busy` and `done` are mutually exclusive and purely state-decoded: no combinational path from inputs.
- `sum`, `cout` and `overflow` change only on the completion edge or on reset.

## Test plan

WIDTH=8 for all scenarios.

1. Reset, then add 0x3C+0x5A. Required: after 9 edges `done`=1 for exactly one cycle, `sum`=0x96, `cout`=0, `overflow`=1.
2. Add 0xFF+0x01. Required: `sum`=0x00, `cout`=1, `overflow`=0. Then issue back-to-back at the earliest `ready`: 0x7F+0x00. Required: `sum`=0x7F, `cout`=0, `overflow`=0, and `sum` holds 0x00 until that second `done`.
3. Sub 0x05−0x07. Required: `sum`=0xFE, `cout`=0, `overflow`=0. Sub 0x80−0x01. Required: `sum`=0x7F, `cout`=1, `overflow`=1.
4. Start 0x10+0x20, then toggle `a`/`b`/`sub` and pulse `start` during RUN and during DONE. Required: a single `done`, `sum`=0x30, and no second operation starts.
5. Start 0xAA+0x55, then assert `rst_n`=0 after 4 edges. Required: `ready`=1, `busy`=0 and `sum`=0 immediately, with no `done`. After release, 0x01+0x01 gives `sum`=0x02.
6. Run a random sweep of 200 ops against a golden a±b model. Required: `sum`, `cout` and `overflow` match on every op, and `done` count equals accept count.
